// File: rtl/issue_queue.sv
// Dual-in / dual-out circular instruction buffer between decode and launch select.
// Entries leave strictly in arrival order. A flush empties the queue in one cycle.
module issue_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32,
    parameter int DC_W  = 67
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in1_valid,
    input  logic [PC_W-1:0]          in1_pc,
    input  logic [PC_W-1:0]          in1_npc,
    input  logic [DC_W-1:0]          in1_decodeout,
    input  logic                     in2_valid,
    input  logic [PC_W-1:0]          in2_pc,
    input  logic [PC_W-1:0]          in2_npc,
    input  logic [DC_W-1:0]          in2_decodeout,
    output logic                     in_ready,
    input  logic [3:0]               launch_flag,
    output logic                     out1_valid,
    output logic [PC_W-1:0]          out1_pc,
    output logic [PC_W-1:0]          out1_npc,
    output logic [DC_W-1:0]          out1_decodeout,
    output logic                     out2_valid,
    output logic [PC_W-1:0]          out2_pc,
    output logic [PC_W-1:0]          out2_npc,
    output logic [DC_W-1:0]          out2_decodeout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] npc;
        logic [DC_W-1:0] dc;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [PTR_W-1:0]   head_p1, tail_p1;
    logic [1:0]         push_n, pop_n;
    logic               iss1, iss2;
    entry_t             slot1, slot2;

    assign head_p1 = head_q + PTR_W'(1);
    assign tail_p1 = tail_q + PTR_W'(1);

    // Readiness looks only at the registered count; a same-cycle pop never helps.
    assign in_ready   = (count_q <= CNT_W'(DEPTH - 2));
    assign out1_valid = (count_q >= CNT_W'(1));
    assign out2_valid = (count_q >= CNT_W'(2));

    assign iss1 = (launch_flag[3] | launch_flag[2]) & out1_valid;
    assign iss2 = (launch_flag[1] | launch_flag[0]) & out2_valid;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        push_n  = 2'd0;
        pop_n   = 2'd0;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (in_ready && in1_valid) begin
            push_n = in2_valid ? 2'd2 : 2'd1;
        end
        if (iss1) begin
            pop_n = iss2 ? 2'd2 : 2'd1;
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop_n);
            tail_d  = tail_q + PTR_W'(push_n);
            count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the entry array has no reset; stale contents are hidden by the valid gating below.
    always_ff @(posedge clk) begin
        if (!flush && push_n != 2'd0) begin
            mem_q[tail_q] <= '{pc: in1_pc, npc: in1_npc, dc: in1_decodeout};
            if (push_n == 2'd2) begin
                mem_q[tail_p1] <= '{pc: in2_pc, npc: in2_npc, dc: in2_decodeout};
            end
        end
    end

    assign slot1 = out1_valid ? mem_q[head_q]  : '0;
    assign slot2 = out2_valid ? mem_q[head_p1] : '0;

    assign out1_pc        = slot1.pc;
    assign out1_npc       = slot1.npc;
    assign out1_decodeout = slot1.dc;
    assign out2_pc        = slot2.pc;
    assign out2_npc       = slot2.npc;
    assign out2_decodeout = slot2.dc;
    assign count          = count_q;

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue with hand-computed expectations.
module tb_issue_queue;

    localparam int DEPTH = 8;
    localparam int PC_W  = 32;
    localparam int DC_W  = 67;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in1_valid, in2_valid;
    logic [PC_W-1:0] in1_pc, in1_npc, in2_pc, in2_npc;
    logic [DC_W-1:0] in1_decodeout, in2_decodeout;
    logic            in_ready;
    logic [3:0]      launch_flag;
    logic            out1_valid, out2_valid;
    logic [PC_W-1:0] out1_pc, out1_npc, out2_pc, out2_npc;
    logic [DC_W-1:0] out1_decodeout, out2_decodeout;
    logic [3:0]      count;

    int checks   = 0;
    int failures = 0;

    issue_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .DC_W(DC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in1_valid(in1_valid), .in1_pc(in1_pc), .in1_npc(in1_npc), .in1_decodeout(in1_decodeout),
        .in2_valid(in2_valid), .in2_pc(in2_pc), .in2_npc(in2_npc), .in2_decodeout(in2_decodeout),
        .in_ready(in_ready), .launch_flag(launch_flag),
        .out1_valid(out1_valid), .out1_pc(out1_pc), .out1_npc(out1_npc), .out1_decodeout(out1_decodeout),
        .out2_valid(out2_valid), .out2_pc(out2_pc), .out2_npc(out2_npc), .out2_decodeout(out2_decodeout),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DC_W-1:0] dc_of(input logic [PC_W-1:0] pc);
        return {3'b101, ~pc, pc};
    endfunction

    // Drive one cycle of stimulus, then wait past the edge so outputs can be sampled.
    task automatic cyc(input logic f, input logic v1, input logic [PC_W-1:0] p1,
                       input logic v2, input logic [PC_W-1:0] p2, input logic [3:0] lf);
        flush         = f;
        in1_valid     = v1;
        in1_pc        = p1;
        in1_npc       = p1 + 32'd4;
        in1_decodeout = dc_of(p1);
        in2_valid     = v2;
        in2_pc        = p2;
        in2_npc       = p2 + 32'd4;
        in2_decodeout = dc_of(p2);
        launch_flag   = lf;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 4'b0000);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0; in1_valid = 1'b0; in2_valid = 1'b0; launch_flag = 4'b0;
        in1_pc = '0; in1_npc = '0; in2_pc = '0; in2_npc = '0;
        in1_decodeout = '0; in2_decodeout = '0;
        #12;
        check("rst_count",  count, 0);
        check("rst_v1",     out1_valid, 0);
        check("rst_v2",     out2_valid, 0);
        check("rst_ready",  in_ready, 1);
        check("rst_pc1",    out1_pc, 0);
        check("rst_dc2",    out2_decodeout, 0);
        rst = 1'b0;

        // First push pair becomes visible the following cycle.
        cyc(1'b0, 1'b1, 32'h100, 1'b1, 32'h104, 4'b0000);
        check("push_pc1",   out1_pc, 32'h100);
        check("push_pc2",   out2_pc, 32'h104);
        check("push_npc1",  out1_npc, 32'h104);
        check("push_dc2",   out2_decodeout, {3'b101, 32'hFFFF_FEFB, 32'h104});
        check("push_v1",    out1_valid, 1);
        check("push_v2",    out2_valid, 1);
        check("push_count", count, 2);

        // Fill to full.
        cyc(1'b0, 1'b1, 32'h108, 1'b1, 32'h10c, 4'b0000);
        cyc(1'b0, 1'b1, 32'h110, 1'b1, 32'h114, 4'b0000);
        check("fill6_count", count, 6);
        check("fill6_ready", in_ready, 1);
        cyc(1'b0, 1'b1, 32'h118, 1'b1, 32'h11c, 4'b0000);
        check("full_count", count, 8);
        check("full_ready", in_ready, 0);
        cyc(1'b0, 1'b1, 32'h120, 1'b1, 32'h124, 4'b0000);
        check("full_hold_count", count, 8);
        check("full_hold_pc1",   out1_pc, 32'h100);
        // A pop while full does not let the same-cycle push in.
        cyc(1'b0, 1'b1, 32'h120, 1'b1, 32'h124, 4'b1000);
        check("full_pop_count", count, 7);
        check("full_pop_pc1",   out1_pc, 32'h104);

        cyc(1'b1, 1'b0, '0, 1'b0, '0, 4'b0000);
        check("flush_count", count, 0);

        // Single pop, then blocked out-of-order issue.
        cyc(1'b0, 1'b1, 32'h200, 1'b1, 32'h204, 4'b0000);
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 4'b1000);
        check("pop1_count", count, 1);
        check("pop1_pc1",   out1_pc, 32'h204);
        check("pop1_v2",    out2_valid, 0);
        check("pop1_pc2",   out2_pc, 0);
        cyc(1'b0, 1'b1, 32'h208, 1'b1, 32'h20c, 4'b0010);
        check("nopop_count", count, 3);
        check("nopop_pc1",   out1_pc, 32'h204);
        check("nopop_pc2",   out2_pc, 32'h208);
        cyc(1'b0, 1'b0, 32'h300, 1'b1, 32'h304, 4'b0000);
        check("in2only_count", count, 3);
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 4'b0101);
        check("pop2_count", count, 1);
        check("pop2_pc1",   out1_pc, 32'h20c);

        // Steady two-in / two-out stream across the pointer wrap.
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 4'b0000);
        cyc(1'b0, 1'b1, 32'h0, 1'b1, 32'h4, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 32'(8 + 8*i), 1'b1, 32'(12 + 8*i), 4'b1001);
            check("wrap_pc1",   out1_pc, 32'(8 + 8*i));
            check("wrap_pc2",   out2_pc, 32'(12 + 8*i));
            check("wrap_count", count, 2);
        end

        // At DEPTH-2, push 2 and pop 2 keeps the count.
        cyc(1'b0, 1'b1, 32'h58, 1'b1, 32'h5c, 4'b0000);
        cyc(1'b0, 1'b1, 32'h60, 1'b1, 32'h64, 4'b0000);
        check("d2_pre_count", count, 6);
        cyc(1'b0, 1'b1, 32'h68, 1'b1, 32'h6c, 4'b1010);
        check("d2_count", count, 6);
        check("d2_pc1",   out1_pc, 32'h58);
        check("d2_pc2",   out2_pc, 32'h5c);

        // Flush overrides a simultaneous push and pop.
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 4'b0000);
        cyc(1'b0, 1'b1, 32'h300, 1'b1, 32'h304, 4'b0000);
        cyc(1'b0, 1'b1, 32'h308, 1'b1, 32'h30c, 4'b0000);
        check("pf_count", count, 4);
        cyc(1'b1, 1'b1, 32'h310, 1'b1, 32'h314, 4'b1001);
        check("fl_count", count, 0);
        check("fl_v1",    out1_valid, 0);
        check("fl_v2",    out2_valid, 0);
        check("fl_ready", in_ready, 1);
        check("fl_pc1",   out1_pc, 0);
        cyc(1'b0, 1'b1, 32'h400, 1'b0, '0, 4'b0000);
        check("postfl_count", count, 1);
        check("postfl_pc1",   out1_pc, 32'h400);

        // Asynchronous reset mid-stream.
        cyc(1'b0, 1'b1, 32'h404, 1'b1, 32'h408, 4'b0000);
        cyc(1'b0, 1'b1, 32'h40c, 1'b1, 32'h410, 4'b0000);
        check("ar_pre_count", count, 5);
        idle();
        #2;
        rst = 1'b1;
        #1;
        check("ar_count", count, 0);
        check("ar_v1",    out1_valid, 0);
        check("ar_v2",    out2_valid, 0);
        check("ar_pc1",   out1_pc, 0);
        check("ar_npc2",  out2_npc, 0);
        check("ar_ready", in_ready, 1);
        #3;
        rst = 1'b0;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
